// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - recovers hex nibbles from a multiplexed active-high 7-segment bus
// Synchronise, filter for stability, reverse-decode and store one nibble per digit.
module seven_seg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [6:0]                    seg_in,
    input  logic [NUM_DIGITS-1:0]         dig_sel,
    input  logic                          clear,
    output logic [4*NUM_DIGITS-1:0]       digits_out,
    output logic [NUM_DIGITS-1:0]         digit_valid,
    output logic                          upd_strobe,
    output logic [$clog2(NUM_DIGITS)-1:0] upd_index,
    output logic [3:0]                    upd_value,
    output logic                          upd_err,
    output logic                          err_sticky
);

    localparam int IDXW = $clog2(NUM_DIGITS);
    localparam int SW   = NUM_DIGITS + 7;
    localparam int CNTW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        TRACK   = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // Reset asserts at once but releases only on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_int;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst_int = rst | rst_sync_q[1];

    logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
    logic [SW-1:0]                  sample;
    logic [SW-1:0]                  prev_q;
    logic [6:0]                     seg_s;
    logic [NUM_DIGITS-1:0]          dig_s;
    logic                           same;
    logic                           onehot;
    logic [IDXW-1:0]                dig_idx;

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= {dig_sel, seg_in};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sample;
        end
    end

    assign sample = sync_q[SYNC_STAGES-1];
    assign seg_s  = sample[6:0];
    assign dig_s  = sample[SW-1:7];
    assign same   = (sample == prev_q);
    assign onehot = (dig_s != '0) && ((dig_s & (dig_s - NUM_DIGITS'(1))) == '0);

    always_comb begin
        dig_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_s[i]) begin
                dig_idx = IDXW'(i);
            end
        end
    end

    // Result is {legal, nibble}; blank and illegal both come back as 0.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F:   decode = {1'b1, 4'h0};
            7'h06:   decode = {1'b1, 4'h1};
            7'h5B:   decode = {1'b1, 4'h2};
            7'h4F:   decode = {1'b1, 4'h3};
            7'h66:   decode = {1'b1, 4'h4};
            7'h6D:   decode = {1'b1, 4'h5};
            7'h7D:   decode = {1'b1, 4'h6};
            7'h07:   decode = {1'b1, 4'h7};
            7'h7F:   decode = {1'b1, 4'h8};
            7'h6F:   decode = {1'b1, 4'h9};
            7'h77:   decode = {1'b1, 4'hA};
            7'h7C:   decode = {1'b1, 4'hB};
            7'h39:   decode = {1'b1, 4'hC};
            7'h5E:   decode = {1'b1, 4'hD};
            7'h79:   decode = {1'b1, 4'hE};
            7'h71:   decode = {1'b1, 4'hF};
            default: decode = 5'h00;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            capture_go;

    assign cnt_inc = (cnt_q == CNTW'(STABLE_CYCLES)) ? cnt_q : cnt_q + CNTW'(1);

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q <= TRACK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = TRACK;
            cnt_d   = '0;
        end else begin
            case (state_q)
                TRACK: begin
                    cnt_d = same ? cnt_inc : CNTW'(1);
                    if (cnt_d == CNTW'(STABLE_CYCLES)) begin
                        state_d = onehot ? CAPTURE : HOLD;
                    end
                end
                // A change landing on the strobe cycle restarts tracking rather than being lost.
                CAPTURE: begin
                    if (same) begin
                        state_d = HOLD;
                    end else begin
                        state_d = TRACK;
                        cnt_d   = CNTW'(1);
                    end
                end
                HOLD: begin
                    if (!same) begin
                        state_d = TRACK;
                        cnt_d   = CNTW'(1);
                    end
                end
                default: begin
                    state_d = TRACK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        capture_go = (state_q == TRACK) && (state_d == CAPTURE);
        upd_strobe = (state_q == CAPTURE) && !clear;
    end

    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   valid_q;
    logic [IDXW-1:0]         idx_q;
    logic [3:0]              value_q;
    logic                    err_q;
    logic                    sticky_q;
    logic [4:0]              decoded;

    assign decoded = decode(seg_s);

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            digits_q <= '0;
            valid_q  <= '0;
            idx_q    <= '0;
            value_q  <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else if (clear) begin
            digits_q <= '0;
            valid_q  <= '0;
            sticky_q <= 1'b0;
        end else if (capture_go) begin
            idx_q <= dig_idx;
            if (decoded[4]) begin
                digits_q[4*dig_idx +: 4] <= decoded[3:0];
                valid_q[dig_idx]         <= 1'b1;
                value_q                  <= decoded[3:0];
                err_q                    <= 1'b0;
            end else if (seg_s == 7'h00) begin
                valid_q[dig_idx] <= 1'b0;
                value_q          <= 4'h0;
                err_q            <= 1'b0;
            end else begin
                valid_q[dig_idx] <= 1'b0;
                value_q          <= 4'h0;
                err_q            <= 1'b1;
                sticky_q         <= 1'b1;
            end
        end
    end

    assign digits_out  = digits_q;
    assign digit_valid = valid_q;
    assign upd_index   = idx_q;
    assign upd_value   = value_q;
    assign upd_err     = err_q;
    assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb/tb_seven_seg_capture.sv - directed self-checking bench for seven_seg_capture
module tb_seven_seg_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic        clear;
    logic [15:0] digits_out;
    logic [3:0]  digit_valid;
    logic        upd_strobe;
    logic [1:0]  upd_index;
    logic [3:0]  upd_value;
    logic        upd_err;
    logic        err_sticky;

    int pass_cnt   = 0;
    int total_cnt  = 0;
    int fail_cnt   = 0;
    int strobe_cnt = 0;

    logic [1:0] last_idx = '0;
    logic [3:0] last_val = '0;
    logic       last_err = 1'b0;

    always #5 clk = ~clk;

    seven_seg_capture #(
        .NUM_DIGITS   (4),
        .STABLE_CYCLES(4),
        .SYNC_STAGES  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .dig_sel    (dig_sel),
        .clear      (clear),
        .digits_out (digits_out),
        .digit_valid(digit_valid),
        .upd_strobe (upd_strobe),
        .upd_index  (upd_index),
        .upd_value  (upd_value),
        .upd_err    (upd_err),
        .err_sticky (err_sticky)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (upd_strobe === 1'b1) begin
                strobe_cnt++;
                last_idx = upd_index;
                last_val = upd_value;
                last_err = upd_err;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        clear   = 1'b0;
        seg_in  = 7'($urandom);
        dig_sel = 4'($urandom);
        tick(3);
        chk("rst_digits", 32'(digits_out), 32'h0);
        chk("rst_valid", 32'(digit_valid), 32'h0);
        chk("rst_strobe", 32'(upd_strobe), 32'h0);
        chk("rst_sticky", 32'(err_sticky), 32'h0);

        seg_in  = 7'h00;
        dig_sel = 4'b0000;
        rst     = 1'b0;
        tick(20);
        chk("idle_strobes", 32'(strobe_cnt), 32'd0);
        chk("idle_digits", 32'(digits_out), 32'h0);
        chk("idle_valid", 32'(digit_valid), 32'h0);
        chk("idle_sticky", 32'(err_sticky), 32'h0);

        // Legal glyph on digit 1: strobe lands on the sixth edge after the change.
        dig_sel = 4'b0010;
        seg_in  = 7'h5B;
        tick(5);
        chk("d1_early", 32'(strobe_cnt), 32'd0);
        tick(1);
        chk("d1_strobe", 32'(upd_strobe), 32'h1);
        chk("d1_index", 32'(upd_index), 32'd1);
        chk("d1_value", 32'(upd_value), 32'h2);
        chk("d1_err", 32'(upd_err), 32'h0);
        tick(14);
        chk("d1_single", 32'(strobe_cnt), 32'd1);
        chk("d1_digits", 32'(digits_out), 32'h0020);
        chk("d1_valid", 32'(digit_valid), 32'h2);

        // Glitch rejection on digit 0.
        dig_sel = 4'b0001;
        seg_in  = 7'h06;
        tick(10);
        chk("d0_first_val", 32'(last_val), 32'h1);
        strobe_cnt = 0;
        seg_in = 7'h7F;
        tick(2);
        seg_in = 7'h06;
        tick(5);
        chk("glitch_none", 32'(strobe_cnt), 32'd0);
        tick(1);
        chk("glitch_strobe", 32'(upd_strobe), 32'h1);
        chk("glitch_value", 32'(upd_value), 32'h1);
        tick(10);
        chk("glitch_single", 32'(strobe_cnt), 32'd1);
        chk("glitch_digits", 32'(digits_out), 32'h0021);
        chk("glitch_valid", 32'(digit_valid), 32'h3);

        // Illegal pattern on digit 0, then clear.
        seg_in = 7'h7E;
        tick(6);
        chk("ill_strobe", 32'(upd_strobe), 32'h1);
        chk("ill_err", 32'(upd_err), 32'h1);
        chk("ill_value", 32'(upd_value), 32'h0);
        chk("ill_index", 32'(upd_index), 32'd0);
        chk("ill_valid", 32'(digit_valid), 32'h2);
        chk("ill_digits", 32'(digits_out), 32'h0021);
        chk("ill_sticky", 32'(err_sticky), 32'h1);
        clear   = 1'b1;
        dig_sel = 4'b0000;
        tick(1);
        clear = 1'b0;
        chk("clr_sticky", 32'(err_sticky), 32'h0);
        chk("clr_digits", 32'(digits_out), 32'h0);
        chk("clr_valid", 32'(digit_valid), 32'h0);

        // Two digits selected at once never captures.
        strobe_cnt = 0;
        dig_sel    = 4'b0011;
        seg_in     = 7'h3F;
        tick(15);
        chk("multi_none", 32'(strobe_cnt), 32'd0);

        // Digit 3 shows A, then goes blank.
        dig_sel = 4'b1000;
        seg_in  = 7'h77;
        tick(10);
        chk("d3_count", 32'(strobe_cnt), 32'd1);
        chk("d3_idx", 32'(last_idx), 32'd3);
        chk("d3_val", 32'(last_val), 32'hA);
        chk("d3_digits", 32'(digits_out), 32'hA000);
        chk("d3_valid", 32'(digit_valid), 32'h8);
        seg_in = 7'h00;
        tick(10);
        chk("blank_count", 32'(strobe_cnt), 32'd2);
        chk("blank_err", 32'(last_err), 32'h0);
        chk("blank_val", 32'(last_val), 32'h0);
        chk("blank_valid", 32'(digit_valid), 32'h0);
        chk("blank_digits", 32'(digits_out), 32'hA000);
        chk("blank_sticky", 32'(err_sticky), 32'h0);

        // Reset mid-window (cnt=3), then a fresh window after release.
        dig_sel = 4'b0100;
        seg_in  = 7'h6D;
        tick(5);
        rst = 1'b1;
        #1;
        chk("arst_digits", 32'(digits_out), 32'h0);
        chk("arst_valid", 32'(digit_valid), 32'h0);
        chk("arst_strobe", 32'(upd_strobe), 32'h0);
        chk("arst_index", 32'(upd_index), 32'd0);
        tick(2);
        rst        = 1'b0;
        strobe_cnt = 0;
        tick(6);
        chk("arst_early", 32'(strobe_cnt), 32'd0);
        tick(24);
        chk("arst_single", 32'(strobe_cnt), 32'd1);
        chk("arst_val", 32'(last_val), 32'h5);
        chk("arst_idx", 32'(last_idx), 32'd2);
        chk("arst_digits2", 32'(digits_out), 32'h0500);
        chk("arst_valid2", 32'(digit_valid), 32'h4);

        // Clear on the capture edge drops that capture.
        strobe_cnt = 0;
        seg_in     = 7'h5B;
        tick(5);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("race_strobe", 32'(upd_strobe), 32'h0);
        chk("race_digits", 32'(digits_out), 32'h0);
        chk("race_count", 32'(strobe_cnt), 32'd0);
        tick(4);
        chk("race_after", 32'(strobe_cnt), 32'd1);
        chk("race_val", 32'(last_val), 32'h2);
        chk("race_digits2", 32'(digits_out), 32'h0200);
        chk("race_valid", 32'(digit_valid), 32'h4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
